// File: rtl/pc_gen_ras.sv
// pc_gen_ras: fetch PC generator with priority redirects and a circular return-address stack.
module pc_gen_ras #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     INC       = 4,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0004,
  parameter int unsigned     RAS_DEPTH = 4,
  localparam int unsigned    PW        = $clog2(RAS_DEPTH),
  localparam int unsigned    CW        = PW + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            trap,
  input  logic            flush_valid,
  input  logic [XLEN-1:0] flush_target,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            call,
  input  logic            ret,
  output logic [XLEN-1:0] pcf,
  output logic [XLEN-1:0] pcf_plus,
  output logic [CW-1:0]   ras_count,
  output logic            ras_underflow,
  output logic            pc_misalign
);
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);
  logic [XLEN-1:0] r_pcf;
  logic [XLEN-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0]   r_ptr;
  logic [CW-1:0]   r_cnt;
  logic            r_uf;
  logic            w_upd, w_has, w_push, w_pop, w_repl;
  logic [PW-1:0]   w_ptrm1, w_widx, w_nptr;
  logic [CW-1:0]   w_ncnt;
  logic [XLEN-1:0] w_plus, w_top, w_npc;
  always_comb begin
    w_plus  = r_pcf + XLEN'(INC);
    w_upd   = !trap && !flush_valid && !stall;
    w_has   = r_cnt != '0;
    w_ptrm1 = r_ptr - 1'b1;
    w_top   = r_ras[w_ptrm1];
    // call+ret with a live entry swaps the top in place instead of push/pop
    w_repl  = call && ret && w_has;
    w_push  = call && !w_repl;
    w_pop   = ret && w_has && !call;
    w_widx  = w_repl ? w_ptrm1 : r_ptr;
    w_nptr  = w_push ? r_ptr + 1'b1 : w_pop ? w_ptrm1 : r_ptr;
    w_ncnt  = w_push ? (r_cnt == FULL ? r_cnt : r_cnt + 1'b1) : w_pop ? r_cnt - 1'b1 : r_cnt;
    w_npc   = trap ? TRAP_VEC : flush_valid ? flush_target : stall ? r_pcf :
              (ret && w_has) ? w_top : br_taken ? br_target : w_plus;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pcf <= RESET_VEC;
      r_ptr <= '0;
      r_cnt <= '0;
      r_uf  <= 1'b0;
    end else begin
      r_pcf <= w_npc;
      r_uf  <= w_upd && ret && !w_has;
      if (w_upd) begin
        if (call) r_ras[w_widx] <= w_plus;
        r_ptr <= w_nptr;
        r_cnt <= w_ncnt;
      end
    end
  end
  assign pcf           = r_pcf;
  assign pcf_plus      = w_plus;
  assign ras_count     = r_cnt;
  assign ras_underflow = r_uf;
  assign pc_misalign   = r_pcf[1:0] != 2'b00;
endmodule
